// File: rtl/accel_pkg.sv
// Shared constants and types for the accelerator tile loader.
package accel_pkg;

  // Job geometry: 4 image rows of 4 bytes, then 3 mask rows of 3 bytes.
  localparam int unsigned ImgBytes  = 16;
  localparam int unsigned MaskBytes = 9;
  localparam int unsigned JobBytes  = 25;

  // Register offsets relative to the accelerator base address.
  localparam logic [31:0] OffCtrl  = 32'h0000_0020;
  localparam logic [31:0] OffImg0  = 32'h0000_0028;
  localparam logic [31:0] OffImg1  = 32'h0000_002C;
  localparam logic [31:0] OffImg2  = 32'h0000_0030;
  localparam logic [31:0] OffImg3  = 32'h0000_0034;
  localparam logic [31:0] OffMask0 = 32'h0000_0038;
  localparam logic [31:0] OffMask1 = 32'h0000_003C;
  localparam logic [31:0] OffMask2 = 32'h0000_0040;
  localparam logic [31:0] OffRes   = 32'h0000_0044;

  typedef enum logic [2:0] {
    StLoad,
    StWr,
    StGo,
    StSettle,
    StRd,
    StOut
  } state_e;

  // True when byte index idx is the last byte of an image or mask row.
  function automatic logic word_end(input logic [4:0] idx);
    if (idx < 5'(ImgBytes)) begin
      return idx[1:0] == 2'd3;
    end
    return (idx == 5'd18) || (idx == 5'd21) || (idx == 5'd24);
  endfunction

  // Register offset of the word just completed, keyed by bytes accepted so far.
  function automatic logic [31:0] word_offset(input logic [4:0] n_bytes);
    case (n_bytes)
      5'd4:    return OffImg0;
      5'd8:    return OffImg1;
      5'd12:   return OffImg2;
      5'd16:   return OffImg3;
      5'd19:   return OffMask0;
      5'd22:   return OffMask1;
      5'd25:   return OffMask2;
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/tile_word_packer.sv
// Byte-to-word packer: first byte of a row lands in [31:24]; mask rows leave [7:0] zero.
module tile_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        shift_en,
  input  logic [7:0]  din,
  input  logic        mask_mode,
  output logic [31:0] word
);

  logic [31:0] acc_q;

  // Shift each accepted byte in from the bottom.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 32'h0;
    end else if (shift_en) begin
      acc_q <= {acc_q[23:0], din};
    end
  end

  // A mask row is only three bytes deep, so realign it to the top and pad.
  always_comb begin
    word = mask_mode ? {acc_q[23:0], 8'h00} : acc_q;
  end

endmodule

// File: rtl/accel_tile_loader.sv
// Streams a 25-byte tile job into the accelerator registers, kicks it, and returns the result.
module accel_tile_loader
  import accel_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        px_valid,
  input  logic [7:0]  px_data,
  input  logic        px_last,
  output logic        px_ready,
  output logic [31:0] bus_addr,
  output logic        bus_wr_en,
  output logic        bus_sel,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  output logic        res_valid,
  output logic [31:0] res_data,
  input  logic        res_ready,
  output logic        busy,
  output logic        err
);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;      // bytes accepted in the current job
  logic [7:0]  settle_q, settle_d;
  logic        err_q, err_d;
  logic [31:0] res_q, res_d;
  logic        live_q;            // keeps px_ready low until the first clock after reset

  logic        accept;
  logic        mask_mode;
  logic [31:0] word;

  assign accept    = px_valid && px_ready;
  assign mask_mode = cnt_q > 5'(ImgBytes);

  tile_word_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_en  (accept),
    .din       (px_data),
    .mask_mode (mask_mode),
    .word      (word)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StLoad;
      cnt_q    <= 5'd0;
      settle_q <= 8'd0;
      err_q    <= 1'b0;
      res_q    <= 32'h0;
      live_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      res_q    <= res_d;
      live_q   <= 1'b1;
    end
  end

  // Next-state, byte counting, framing error and result capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    err_d    = err_q;
    res_d    = res_q;
    unique case (state_q)
      StLoad: begin
        if (accept) begin
          cnt_d = cnt_q + 5'd1;
          if (px_last != (cnt_q == 5'(JobBytes - 1))) begin
            err_d = 1'b1;
          end
          if (word_end(cnt_q)) begin
            state_d = StWr;
          end
        end
      end
      StWr: begin
        state_d = (cnt_q == 5'(JobBytes)) ? StGo : StLoad;
      end
      StGo: begin
        settle_d = 8'd0;
        state_d  = StSettle;
      end
      StSettle: begin
        if (settle_q == 8'(SETTLE_CYC - 1)) begin
          state_d = StRd;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      StRd: begin
        res_d   = bus_rdata;
        state_d = StOut;
      end
      StOut: begin
        if (res_ready) begin
          cnt_d   = 5'd0;
          state_d = StLoad;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  // Bus and handshake outputs decoded from state.
  always_comb begin
    px_ready  = 1'b0;
    bus_addr  = 32'h0;
    bus_wr_en = 1'b0;
    bus_sel   = 1'b0;
    bus_wdata = 32'h0;
    res_valid = 1'b0;
    unique case (state_q)
      StLoad: px_ready = live_q;
      StWr: begin
        bus_addr  = BASE_ADDR + word_offset(cnt_q);
        bus_wr_en = 1'b1;
        bus_sel   = 1'b1;
        bus_wdata = word;
      end
      StGo: begin
        bus_addr  = BASE_ADDR + OffCtrl;
        bus_wr_en = 1'b1;
        bus_sel   = 1'b1;
        bus_wdata = 32'h1;
      end
      StRd: begin
        bus_addr = BASE_ADDR + OffRes;
        bus_sel  = 1'b1;
      end
      StOut:    res_valid = 1'b1;
      default: ;
    endcase
  end

  assign busy     = !((state_q == StLoad) && (cnt_q == 5'd0));
  assign err      = err_q;
  assign res_data = res_q;

endmodule

// File: tb/tb_accel_tile_loader.sv
// Directed bench for accel_tile_loader: one task per scenario, inline checks.
module tb_accel_tile_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Primary DUT, SETTLE_CYC = 2.
  logic        px_valid = 1'b0, px_last = 1'b0, res_ready = 1'b0;
  logic [7:0]  px_data = 8'h0;
  logic        px_ready, bus_wr_en, bus_sel, res_valid, busy, err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata, res_data;
  logic [31:0] rd_val = 32'h0;

  // Second DUT, SETTLE_CYC = 5.
  logic        px_valid2 = 1'b0, px_last2 = 1'b0, res_ready2 = 1'b0;
  logic [7:0]  px_data2 = 8'h0;
  logic        px_ready2, bus_wr_en2, bus_sel2, res_valid2, busy2, err2;
  logic [31:0] bus_addr2, bus_wdata2, bus_rdata2, res_data2;

  int n_pass = 0;
  int n_total = 0;
  int idle_bad = 0;
  int sel_bad = 0;

  logic [7:0]  job_b [25];
  logic [31:0] wq_a [$];
  logic [31:0] wq_d [$];

  // Accelerator read model: only the result register returns data.
  assign bus_rdata  = (bus_sel && !bus_wr_en && bus_addr == 32'h44) ? rd_val : 32'h0;
  assign bus_rdata2 = (bus_sel2 && !bus_wr_en2 && bus_addr2 == 32'h44) ? 32'hA5A5_0005 : 32'h0;

  accel_tile_loader #(.BASE_ADDR(32'h0), .SETTLE_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .px_valid(px_valid), .px_data(px_data), .px_last(px_last),
    .px_ready(px_ready), .bus_addr(bus_addr), .bus_wr_en(bus_wr_en), .bus_sel(bus_sel),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .res_valid(res_valid), .res_data(res_data),
    .res_ready(res_ready), .busy(busy), .err(err)
  );

  accel_tile_loader #(.BASE_ADDR(32'h0), .SETTLE_CYC(5)) dut2 (
    .clk(clk), .rst_n(rst_n), .px_valid(px_valid2), .px_data(px_data2), .px_last(px_last2),
    .px_ready(px_ready2), .bus_addr(bus_addr2), .bus_wr_en(bus_wr_en2), .bus_sel(bus_sel2),
    .bus_wdata(bus_wdata2), .bus_rdata(bus_rdata2), .res_valid(res_valid2),
    .res_data(res_data2), .res_ready(res_ready2), .busy(busy2), .err(err2)
  );

  // Bus monitor for the primary DUT.
  always @(negedge clk) begin
    if (bus_wr_en === 1'b1) begin
      wq_a.push_back(bus_addr);
      wq_d.push_back(bus_wdata);
      if (bus_sel !== 1'b1) sel_bad++;
    end
    if (rst_n && bus_sel === 1'b0 &&
        (bus_addr !== 32'h0 || bus_wdata !== 32'h0 || bus_wr_en !== 1'b0)) idle_bad++;
  end

  task automatic send_byte(input bit which, input logic [7:0] b, input logic last);
    int n = 0;
    if (which) begin px_valid2 = 1'b1; px_data2 = b; px_last2 = last; end
    else begin px_valid = 1'b1; px_data = b; px_last = last; end
    while (((which ? px_ready2 : px_ready) !== 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_total++;
      $display("FAIL byte_timeout: px_ready never rose (byte %h)", b);
    end
    @(negedge clk);
    px_valid = 1'b0; px_last = 1'b0; px_valid2 = 1'b0; px_last2 = 1'b0;
  endtask

  task automatic send_job(input bit which, input bit gap, input int last_idx);
    for (int i = 0; i < 25; i++) begin
      send_byte(which, job_b[i], i == last_idx);
      if (gap && i != 24) @(negedge clk);
    end
  endtask

  // Counts negedges from the one right after the last byte (k=1 is the WR cycle).
  task automatic wait_result(output int rd_k, output int rv_k);
    int k = 1;
    rd_k = 0;
    while (res_valid !== 1'b1 && k < 60) begin
      if (rd_k == 0 && bus_sel === 1'b1 && bus_wr_en === 1'b0 && bus_addr === 32'h44) rd_k = k;
      @(negedge clk);
      k++;
    end
    rv_k = (res_valid === 1'b1) ? k : -1;
  endtask

  task automatic finish_result();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic expect_write_seq(input string tag);
    logic [31:0] ea, ed;
    n_total++;
    if (wq_a.size() !== 8) $display("FAIL %s_count: got %0d writes, exp 8", tag, wq_a.size());
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        ea = 32'h28 + 32'(4 * i);
        ed = {job_b[4*i], job_b[4*i+1], job_b[4*i+2], job_b[4*i+3]};
      end else if (i < 7) begin
        ea = 32'h38 + 32'(4 * (i - 4));
        ed = {job_b[16+3*(i-4)], job_b[17+3*(i-4)], job_b[18+3*(i-4)], 8'h00};
      end else begin
        ea = 32'h20;
        ed = 32'h1;
      end
      if (i < wq_a.size()) begin
        n_total++;
        if (wq_a[i] !== ea) $display("FAIL %s_addr%0d: got %h exp %h", tag, i, wq_a[i], ea);
        else n_pass++;
        n_total++;
        if (wq_d[i] !== ed) $display("FAIL %s_data%0d: got %h exp %h", tag, i, wq_d[i], ed);
        else n_pass++;
      end
    end
  endtask

  task automatic fill_basic();
    for (int i = 0; i < 25; i++) job_b[i] = (i < 16) ? 8'(i + 1) : 8'h01;
  endtask

  task automatic test_reset();
    #12;
    n_total++; if (px_ready !== 1'b0) $display("FAIL rst_px_ready: got %b exp 0", px_ready);
    else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", busy); else n_pass++;
    n_total++; if (res_valid !== 1'b0 || err !== 1'b0)
      $display("FAIL rst_valid_err: got %b%b exp 00", res_valid, err); else n_pass++;
    n_total++; if (bus_sel !== 1'b0 || bus_wr_en !== 1'b0)
      $display("FAIL rst_bus: got %b%b exp 00", bus_sel, bus_wr_en); else n_pass++;
    n_total++; if (res_data !== 32'h0) $display("FAIL rst_res_data: got %h exp 0", res_data);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_total++; if (px_ready !== 1'b0) $display("FAIL rel_px_ready_early: got %b exp 0", px_ready);
    else n_pass++;
    @(negedge clk);
    n_total++; if (px_ready !== 1'b1) $display("FAIL rel_px_ready: got %b exp 1", px_ready);
    else n_pass++;
  endtask

  task automatic test_basic();
    int rd_k, rv_k;
    fill_basic();
    rd_val = 32'hCAFE_0001;
    wq_a.delete(); wq_d.delete();
    send_job(1'b0, 1'b0, 24);
    wait_result(rd_k, rv_k);
    n_total++; if (rd_k !== 5) $display("FAIL basic_rd_cycle: got %0d exp 5", rd_k); else n_pass++;
    n_total++; if (rv_k !== 6) $display("FAIL basic_valid_cycle: got %0d exp 6", rv_k);
    else n_pass++;
    expect_write_seq("basic");
    n_total++; if (wq_d.size() < 8 || wq_d[0] !== 32'h0102_0304 || wq_d[3] !== 32'h0D0E_0F10 ||
                   wq_d[4] !== 32'h0101_0100 || wq_a[7] !== 32'h20)
      $display("FAIL basic_literal: first word got %h exp 01020304", wq_d.size() ? wq_d[0] : 0);
    else n_pass++;
    n_total++; if (res_data !== 32'hCAFE_0001)
      $display("FAIL basic_res_data: got %h exp cafe0001", res_data); else n_pass++;
    n_total++; if (err !== 1'b0 || busy !== 1'b1)
      $display("FAIL basic_err_busy: got %b%b exp 01", err, busy); else n_pass++;
    finish_result();
    n_total++; if (res_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL basic_after_hs: got %b%b exp 00", res_valid, busy); else n_pass++;
  endtask

  task automatic test_gap();
    int rd_k, rv_k;
    fill_basic();
    rd_val = 32'h0000_BEEF;
    wq_a.delete(); wq_d.delete();
    send_job(1'b0, 1'b1, 24);
    wait_result(rd_k, rv_k);
    expect_write_seq("gap");
    n_total++; if (rv_k !== 6) $display("FAIL gap_valid_cycle: got %0d exp 6", rv_k);
    else n_pass++;
    n_total++; if (res_data !== 32'h0000_BEEF)
      $display("FAIL gap_res_data: got %h exp 0000beef", res_data); else n_pass++;
    finish_result();
  endtask

  task automatic test_back_to_back();
    int rd_k, rv_k;
    for (int i = 0; i < 25; i++) job_b[i] = 8'(8'hC0 + i);
    rd_val = 32'h1357_9BDF;
    wq_a.delete(); wq_d.delete();
    send_job(1'b0, 1'b0, 24);
    wait_result(rd_k, rv_k);
    rd_val = 32'hDEAD_DEAD;
    px_valid = 1'b1; px_data = 8'hEE;
    for (int c = 0; c < 10; c++) begin
      n_total++; if (res_valid !== 1'b1 || res_data !== 32'h1357_9BDF || px_ready !== 1'b0)
        $display("FAIL hold_c%0d: got v=%b d=%h r=%b exp v=1 d=13579bdf r=0",
                 c, res_valid, res_data, px_ready);
      else n_pass++;
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    px_valid = 1'b0;
    n_total++; if (res_valid !== 1'b0 || px_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL hold_release: got v=%b r=%b b=%b exp 0 1 0", res_valid, px_ready, busy);
    else n_pass++;
    expect_write_seq("hold");
  endtask

  task automatic test_last_early();
    int rd_k, rv_k;
    fill_basic();
    rd_val = 32'h0BAD_F00D;
    wq_a.delete(); wq_d.delete();
    send_job(1'b0, 1'b0, 10);
    wait_result(rd_k, rv_k);
    expect_write_seq("early");
    n_total++; if (err !== 1'b1) $display("FAIL early_err: got %b exp 1", err); else n_pass++;
    n_total++; if (res_data !== 32'h0BAD_F00D)
      $display("FAIL early_res_data: got %h exp 0badf00d", res_data); else n_pass++;
    finish_result();
    repeat (3) @(negedge clk);
    n_total++; if (err !== 1'b1) $display("FAIL early_sticky: got %b exp 1", err); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int rd_k, rv_k;
    for (int i = 0; i < 25; i++) job_b[i] = 8'(8'h30 + 3 * i);
    for (int i = 0; i < 19; i++) send_byte(1'b0, job_b[i], 1'b0);
    // Now in the WR cycle for the first mask row.
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (bus_wr_en !== 1'b0 || bus_sel !== 1'b0 || bus_addr !== 32'h0)
      $display("FAIL midrst_bus: got %b%b %h exp 00 0", bus_wr_en, bus_sel, bus_addr);
    else n_pass++;
    n_total++; if (err !== 1'b0 || px_ready !== 1'b0 || busy !== 1'b0)
      $display("FAIL midrst_flags: got e=%b r=%b b=%b exp 000", err, px_ready, busy);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wq_a.delete(); wq_d.delete();
    rd_val = 32'h2468_ACE0;
    send_job(1'b0, 1'b0, 24);
    wait_result(rd_k, rv_k);
    expect_write_seq("midrst");
    n_total++; if (res_data !== 32'h2468_ACE0 || err !== 1'b0)
      $display("FAIL midrst_res: got %h err=%b exp 2468ace0 0", res_data, err); else n_pass++;
    finish_result();
  endtask

  task automatic test_settle5();
    int k = 1, rd_k = 0, rv_k;
    fill_basic();
    send_job(1'b1, 1'b0, 24);
    while (res_valid2 !== 1'b1 && k < 60) begin
      if (rd_k == 0 && bus_sel2 === 1'b1 && bus_wr_en2 === 1'b0 && bus_addr2 === 32'h44) rd_k = k;
      @(negedge clk);
      k++;
    end
    rv_k = (res_valid2 === 1'b1) ? k : -1;
    n_total++; if (rd_k !== 8) $display("FAIL settle5_rd_cycle: got %0d exp 8", rd_k);
    else n_pass++;
    n_total++; if (rv_k !== 9) $display("FAIL settle5_valid_cycle: got %0d exp 9", rv_k);
    else n_pass++;
    n_total++; if (res_data2 !== 32'hA5A5_0005)
      $display("FAIL settle5_res_data: got %h exp a5a50005", res_data2); else n_pass++;
    res_ready2 = 1'b1;
    @(negedge clk);
    res_ready2 = 1'b0;
    n_total++; if (res_valid2 !== 1'b0 || busy2 !== 1'b0)
      $display("FAIL settle5_after_hs: got %b%b exp 00", res_valid2, busy2); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_back_to_back();
    test_last_early();
    test_reset_mid();
    test_settle5();
    n_total++; if (idle_bad !== 0) $display("FAIL idle_bus: got %0d nonzero cycles exp 0", idle_bad);
    else n_pass++;
    n_total++; if (sel_bad !== 0) $display("FAIL write_sel: got %0d bad writes exp 0", sel_bad);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
